// File: rtl/gate_resp_checker.sv
// Response checker for a 3-input gate: compares the gate output against a golden
// function once per settled stimulus vector, tracks coverage and reports pass/fail.
module gate_resp_checker #(
    parameter int GATE_OP = 0,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       out,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] err_cnt,
    output logic [7:0] chk_cnt,
    output logic [7:0] coverage,
    output logic       fail_valid,
    output logic [2:0] fail_vec,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  stab_cnt;
    logic [2:0]  prev_vec;
    logic [15:0] cyc_cnt;

    logic [2:0]  vec;
    logic        expected;
    logic        restart;
    logic [3:0]  stab_next;
    logic        check;
    logic        mismatch;
    logic [7:0]  err_next;
    logic [7:0]  cov_next;
    logic [15:0] cyc_next;
    logic        complete;
    logic        expired;

    assign vec = {in2, in1, in0};

    always_comb begin
        expected = &vec;
        case (GATE_OP)
            1:       expected = |vec;
            2:       expected = ^vec;
            3:       expected = ~&vec;
            4:       expected = ~|vec;
            5:       expected = ~^vec;
            default: expected = &vec;
        endcase
    end

    // A cleared stab_cnt marks either the first RUN edge or a resume after en=0.
    assign restart   = (state == IDLE) || (stab_cnt == 4'd0) || (vec != prev_vec);
    assign stab_next = restart ? 4'd1 : ((stab_cnt == 4'hF) ? 4'hF : stab_cnt + 4'd1);
    // Saturation at 15 must not re-fire the check while the vector is held.
    assign check     = (stab_next == 4'(SETTLE)) && (restart || (stab_cnt != 4'(SETTLE)));
    assign mismatch  = (out != expected);
    assign err_next  = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    assign cov_next  = coverage | (8'd1 << vec);
    assign cyc_next  = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
    assign complete  = check && (cov_next == 8'hFF);
    assign expired   = (cyc_next == 16'(TIMEOUT));

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            stab_cnt   <= 4'd0;
            prev_vec   <= 3'd0;
            cyc_cnt    <= 16'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= 8'd0;
            chk_cnt    <= 8'd0;
            coverage   <= 8'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else if (state != DONE) begin
            if (!en) begin
                stab_cnt <= 4'd0;
            end else begin
                prev_vec <= vec;
                stab_cnt <= stab_next;
                cyc_cnt  <= cyc_next;
                if (check) begin
                    chk_cnt  <= (chk_cnt == 8'hFF) ? chk_cnt : chk_cnt + 8'd1;
                    coverage <= cov_next;
                    err_cnt  <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                end
                // Completion takes priority over an expiry on the same edge.
                if (complete) begin
                    state <= DONE;
                    done  <= 1'b1;
                    pass  <= (err_next == 8'd0);
                end else if (expired) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: four instances with different parameters share one
// stimulus bus; a scoreboard queue holds the expected final report of the selected one.
module tb_gate_resp_checker;

    typedef struct packed {
        logic       done;
        logic       pass;
        logic       timeout;
        logic [7:0] err_cnt;
        logic [7:0] chk_cnt;
        logic [7:0] coverage;
        logic       fail_valid;
        logic [2:0] fail_vec;
    } res_t;

    localparam int RW = $bits(res_t);
    localparam int OP_TAB[4]  = '{0, 0, 0, 2};
    localparam int SET_TAB[4] = '{1, 3, 1, 1};
    localparam int TMO_TAB[4] = '{64, 64, 10, 64};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] vec = 3'd0;
    int         mode = 0;
    int         sel = 0;
    logic       out_g;
    logic       out_x;
    res_t       r [4];
    logic [1:0] st [4];

    logic [RW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    bit seen = 1'b0;

    // mode 0: correct AND, 1: stuck at 0, 2: inverted AND, 3: XOR with a fault at vec 6
    assign out_g = (mode == 0) ? (&vec) : (mode == 1) ? 1'b0 : ~(&vec);
    assign out_x = (^vec) ^ ((mode == 3) && (vec == 3'd6));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 ns, required finish");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic       done_w, pass_w, tmo_w, fv_w;
        logic [7:0] err_w, chk_w, cov_w;
        logic [2:0] fvec_w;
        logic [1:0] st_w;
        gate_resp_checker #(
            .GATE_OP(OP_TAB[g]),
            .SETTLE (SET_TAB[g]),
            .TIMEOUT(TMO_TAB[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in0       (vec[0]),
            .in1       (vec[1]),
            .in2       (vec[2]),
            .out       ((g == 3) ? out_x : out_g),
            .done      (done_w),
            .pass      (pass_w),
            .timeout   (tmo_w),
            .err_cnt   (err_w),
            .chk_cnt   (chk_w),
            .coverage  (cov_w),
            .fail_valid(fv_w),
            .fail_vec  (fvec_w),
            .state_dbg (st_w)
        );
        assign r[g]  = {done_w, pass_w, tmo_w, err_w, chk_w, cov_w, fv_w, fvec_w};
        assign st[g] = st_w;
    end

    // ---------------- helpers ----------------
    function automatic res_t mk(input logic d, input logic p, input logic t,
                                input logic [7:0] e, input logic [7:0] c,
                                input logic [7:0] cv, input logic fv,
                                input logic [2:0] fvec);
        return {d, p, t, e, c, cv, fv, fvec};
    endfunction

    task automatic check_res(input string name, input int d, input res_t got, input res_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got done=%0b pass=%0b tmo=%0b err=%0d chk=%0d cov=%02h fv=%0b fvec=%0d, required done=%0b pass=%0b tmo=%0b err=%0d chk=%0d cov=%02h fv=%0b fvec=%0d",
                     name, d, got.done, got.pass, got.timeout, got.err_cnt, got.chk_cnt,
                     got.coverage, got.fail_valid, got.fail_vec, exp.done, exp.pass,
                     exp.timeout, exp.err_cnt, exp.chk_cnt, exp.coverage, exp.fail_valid,
                     exp.fail_vec);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] v);
        vec = v;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int new_sel);
        en  = 1'b0;
        vec = 3'd0;
        rst = 1'b0;
        sel = new_sel;
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 4; d++) check_res("reset", d, r[d], mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input res_t e);
        exp_q.push_back(RW'(e));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending reports after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            seen = 1'b0;
        end else if (r[sel].done && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut%0d: got done=1, required no report", sel);
            end else begin
                check_res("final", sel, r[sel], res_t'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] seq_f [10];
        logic [2:0] seq_h [8];
        seq_f = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd6, 3'd7};
        seq_h = '{3'd5, 3'd3, 3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd4};

        // Correct AND, one vector per cycle
        mode = 0;
        do_reset(0);
        en = 1'b1;
        push(mk(1, 1, 0, 0, 8, 8'hFF, 0, 0));
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            if (i == 3) check_val("and_chk_mid", int'(r[0].chk_cnt), 4);
            if (i == 6) check_val("and_done_early", int'(r[0].done), 0);
        end
        @(negedge clk);
        check_val("and_done_timing", int'(r[0].done), 1);
        wait_drain("and_drain", 5);
        mode = 1;
        drive(3'd0);
        drive(3'd1);
        drive(3'd2);
        check_res("done_frozen", 0, r[0], mk(1, 1, 0, 0, 8, 8'hFF, 0, 0));
        check_val("done_state", int'(st[0]), 2);

        // Stuck-at-0 gate: only vec 7 mismatches
        mode = 1;
        do_reset(0);
        en = 1'b1;
        push(mk(1, 0, 0, 1, 8, 8'hFF, 1, 3'd7));
        for (int i = 0; i < 8; i++) drive(3'(i));
        wait_drain("stuck0_drain", 5);

        // Inverted gate: every vector mismatches, first failure is vec 0
        mode = 2;
        do_reset(0);
        en = 1'b1;
        push(mk(1, 0, 0, 8, 8, 8'hFF, 1, 3'd0));
        for (int i = 0; i < 8; i++) drive(3'(i));
        wait_drain("inv_drain", 5);

        // SETTLE=3: two-cycle holds never check, four-cycle holds check once
        mode = 0;
        do_reset(1);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            drive(3'(i));
        end
        check_val("settle_short_chk", int'(r[1].chk_cnt), 0);
        push(mk(1, 1, 0, 0, 8, 8'hFF, 0, 0));
        for (int i = 0; i < 8; i++) begin
            repeat (4) drive(3'(i));
            if (i == 0) check_val("settle_long_first", int'(r[1].chk_cnt), 1);
        end
        wait_drain("settle_drain", 5);

        // TIMEOUT=10 with only vecs 0..3
        mode = 0;
        do_reset(2);
        en = 1'b1;
        push(mk(1, 0, 1, 0, 10, 8'h0F, 0, 0));
        for (int k = 0; k < 12; k++) begin
            drive(3'(k % 4));
            if (k == 8) check_val("tmo_not_yet", int'(r[2].done), 0);
        end
        wait_drain("tmo_drain", 5);

        // TIMEOUT=10 with coverage completing on the 10th edge
        do_reset(2);
        en = 1'b1;
        push(mk(1, 1, 0, 0, 8, 8'hFF, 0, 0));
        for (int k = 0; k < 10; k++) begin
            drive(seq_f[k]);
            if (k == 8) check_val("tie_chk_edge9", int'(r[2].chk_cnt), 7);
        end
        wait_drain("tie_drain", 5);

        // Asynchronous reset mid-run, then a clean rerun
        do_reset(0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) drive(3'(i));
        check_val("midrun_chk", int'(r[0].chk_cnt), 5);
        #1 rst = 1'b0;
        #1;
        check_res("async_clear", 0, r[0], mk(0, 0, 0, 0, 0, 0, 0, 0));
        check_val("async_state", int'(st[0]), 0);
        do_reset(0);
        en = 1'b1;
        push(mk(1, 1, 0, 0, 8, 8'hFF, 0, 0));
        for (int i = 0; i < 8; i++) drive(3'(i));
        wait_drain("rerun_drain", 5);

        // XOR golden model, scrambled order, fault only at vec 6
        mode = 3;
        do_reset(3);
        en = 1'b1;
        push(mk(1, 0, 0, 1, 8, 8'hFF, 1, 3'd6));
        for (int i = 0; i < 8; i++) drive(seq_h[i]);
        wait_drain("xor_drain", 5);

        // en pause: no checks while low, same vector rechecked on resume
        mode = 0;
        do_reset(0);
        en = 1'b1;
        push(mk(1, 1, 0, 0, 9, 8'hFF, 0, 0));
        drive(3'd0);
        drive(3'd1);
        drive(3'd2);
        en = 1'b0;
        drive(3'd3);
        drive(3'd4);
        drive(3'd5);
        check_val("pause_chk", int'(r[0].chk_cnt), 3);
        check_val("pause_cov", int'(r[0].coverage), 8'h07);
        en = 1'b1;
        drive(3'd2);
        check_val("resume_chk", int'(r[0].chk_cnt), 4);
        for (int i = 3; i < 8; i++) drive(3'(i));
        wait_drain("pause_drain", 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
